// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and sequencing controller for the 4-stage IF/ID/EX/MEM pipeline.
// It drives the enable/flush controls of the PC, the IF/ID register (pr1) and
// the ID/EX register (pr2). It resolves:
//   - load-use data hazards, including extra data-memory latency (MEM_LAT)
//   - control redirects resolved in EX, squashing IF/ID for FLUSH_DEPTH cycles
//   - back-to-back accesses to the single-ported return stack
//
// Outputs are Mealy: they are combinational from the FSM state and the
// current inputs. Their effect is seen on the next clk edge. While rst is
// high the outputs are forced to their reset values.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   When defined, adds the saturating performance counters stall_cycles_o
//   and flush_cycles_o. The default build has neither the ports nor the
//   counters.
//
// Ports:
//   clk               in   clock, rising edge
//   rst               in   asynchronous active-high reset
//   id_rs1_i/_rs2_i   in   source registers of the ID instruction
//   id_uses_rs1_i/2_i in   ID instruction reads rs1 / rs2
//   id_is_stack_i     in   ID instruction pushes or pops the return stack
//   ex_valid_i        in   ID/EX holds a real instruction
//   ex_rd_i           in   destination register of the EX instruction
//   ex_mem_read_i     in   EX instruction is a load
//   ex_rf_write_en_i  in   EX instruction writes the register file
//   ex_is_stack_i     in   EX instruction pushes or pops the stack
//   ex_redirect_i     in   EX resolved a PC redirect this cycle
//   pc_en_o           out  PC update enable
//   pr1_en_o          out  IF/ID load enable
//   pr1_flush_o       out  IF/ID loads a bubble
//   pr2_flush_o       out  ID/EX loads a bubble
//   busy_o            out  FSM not in RUN
//   stall_cycles_o    out  (HAZARD_PERF_CNT_EN) cycles with pc_en_o=0
//   flush_cycles_o    out  (HAZARD_PERF_CNT_EN) cycles with pr1_flush_o=1
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 3,
  parameter int MEM_LAT     = 1,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  id_is_stack_i,
  input  logic                  ex_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_rf_write_en_i,
  input  logic                  ex_is_stack_i,
  input  logic                  ex_redirect_i,
  output logic                  pc_en_o,
  output logic                  pr1_en_o,
  output logic                  pr1_flush_o,
  output logic                  pr2_flush_o,
  output logic                  busy_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]           stall_cycles_o,
  output logic [15:0]           flush_cycles_o
`endif
);

  localparam int CNT_MAX = (MEM_LAT > FLUSH_DEPTH) ? MEM_LAT : FLUSH_DEPTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_DEPTH - 1);
  localparam logic [CNT_W-1:0] LAT_RELOAD   = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic redir_s, lu_s, stk_s;
  logic pc_en_s, pr1_en_s, pr1_flush_s, pr2_flush_s, busy_s;

  // Hazard terms against the instruction held in ID/EX.
  always_comb begin
    redir_s = ex_valid_i & ex_redirect_i;
    lu_s    = ex_valid_i & ex_mem_read_i & ex_rf_write_en_i &
              ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
               (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));
    stk_s   = ex_valid_i & ex_is_stack_i & id_is_stack_i;
  end

  // Next-state, counter and unforced Mealy outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_en_s     = 1'b1;
    pr1_en_s    = 1'b1;
    pr1_flush_s = 1'b0;
    pr2_flush_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redir_s) begin
          pr1_flush_s = 1'b1;
          pr2_flush_s = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else if (lu_s) begin
          pc_en_s     = 1'b0;
          pr1_en_s    = 1'b0;
          pr2_flush_s = 1'b1;
          if (MEM_LAT > 0) begin
            state_d = ST_LOAD_STALL;
            cnt_d   = LAT_RELOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else if (stk_s) begin
          // One bubble into EX is enough to serialise the stack port.
          pc_en_s     = 1'b0;
          pr1_en_s    = 1'b0;
          pr2_flush_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD_STALL: begin
        // EX holds a bubble here, so hazard inputs are deliberately ignored.
        pc_en_s     = 1'b0;
        pr1_en_s    = 1'b0;
        pr2_flush_s = 1'b1;
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_FLUSH: begin
        pr1_flush_s = 1'b1;
        if (redir_s) begin
          // A fresh redirect restarts the squash window and kills EX too.
          pr2_flush_s = 1'b1;
          cnt_d       = FLUSH_RELOAD;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d     = ST_RUN;
        cnt_d       = CNT_ZERO;
        pc_en_s     = 1'b0;
        pr1_en_s    = 1'b0;
        pr1_flush_s = 1'b1;
        pr2_flush_s = 1'b1;
      end
    endcase
    busy_s = (state_q != ST_RUN);
  end

  // Output forcing while reset is asserted; otherwise pass the Mealy terms.
  always_comb begin
    if (rst) begin
      pc_en_o     = 1'b0;
      pr1_en_o    = 1'b0;
      pr1_flush_o = 1'b1;
      pr2_flush_o = 1'b1;
      busy_o      = 1'b0;
    end else begin
      pc_en_o     = pc_en_s;
      pr1_en_o    = pr1_en_s;
      pr1_flush_o = pr1_flush_s;
      pr2_flush_o = pr2_flush_s;
      busy_o      = busy_s;
    end
  end

  // FSM state and cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating stall/flush cycle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (!pc_en_o && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (pr1_flush_o && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_cycles_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed-vector bench for pipeline_hazard_ctrl (default parameters:
// REG_ADDR_W=3, MEM_LAT=1, FLUSH_DEPTH=2). Stimulus is applied on the falling
// edge together with a hand-computed expected output vector pushed into a
// queue; a separate monitor pops and compares 3 time units later, before the
// next rising edge.
// Expected vector bit order: {pc_en, pr1_en, pr1_flush, pr2_flush, busy}.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, id_is_stack;
  logic       ex_valid, ex_mem_read, ex_rf_write_en, ex_is_stack, ex_redirect;
  logic       pc_en, pr1_en, pr1_flush, pr2_flush, busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles, flush_cycles;
`endif

  typedef struct {
    string       name;
    logic [4:0]  v;
    bit          perf;
    logic [15:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [4:0] V_RST  = 5'b00110;
  localparam logic [4:0] V_RUN  = 5'b11000;
  localparam logic [4:0] V_LU   = 5'b00010;
  localparam logic [4:0] V_LS   = 5'b00011;
  localparam logic [4:0] V_RD   = 5'b11110;
  localparam logic [4:0] V_FL   = 5'b11101;
  localparam logic [4:0] V_RDF  = 5'b11111;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W  (3),
    .MEM_LAT     (1),
    .FLUSH_DEPTH (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1_i         (id_rs1),
    .id_rs2_i         (id_rs2),
    .id_uses_rs1_i    (id_uses_rs1),
    .id_uses_rs2_i    (id_uses_rs2),
    .id_is_stack_i    (id_is_stack),
    .ex_valid_i       (ex_valid),
    .ex_rd_i          (ex_rd),
    .ex_mem_read_i    (ex_mem_read),
    .ex_rf_write_en_i (ex_rf_write_en),
    .ex_is_stack_i    (ex_is_stack),
    .ex_redirect_i    (ex_redirect),
    .pc_en_o          (pc_en),
    .pr1_en_o         (pr1_en),
    .pr1_flush_o      (pr1_flush),
    .pr2_flush_o      (pr2_flush),
    .busy_o           (busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles_o   (stall_cycles),
    .flush_cycles_o   (flush_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one comparison per queued expectation, sampled mid low phase.
  initial begin
    exp_t       e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pc_en, pr1_en, pr1_flush, pr2_flush, busy};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s: got {pc_en,pr1_en,pr1_flush,pr2_flush,busy}=%b want %b",
                   e.name, act, e.v);
        end
`ifdef HAZARD_PERF_CNT_EN
        if (e.perf) begin
          total++;
          if (stall_cycles !== e.stall) begin
            bad++;
            $display("FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles, e.stall);
          end
        end
`endif
      end
    end
  end

  task automatic expect_v(input string n, input logic [4:0] v);
    exp_t e;
    e.name = n; e.v = v; e.perf = 1'b0; e.stall = 16'd0;
    exp_q.push_back(e);
  endtask

  task automatic expect_p(input string n, input logic [4:0] v, input logic [15:0] s);
    exp_t e;
    e.name = n; e.v = v; e.perf = 1'b1; e.stall = s;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    id_rs1 = 3'd0; id_rs2 = 3'd0; ex_rd = 3'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_is_stack = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rf_write_en = 1'b0;
    ex_is_stack = 1'b0; ex_redirect = 1'b0;
  endtask

  task automatic lu_in(input logic [2:0] rd, input logic [2:0] rs1);
    idle();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rf_write_en = 1'b1;
    ex_rd = rd; id_rs1 = rs1; id_uses_rs1 = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();

    // Reset values while rst is held.
    @(negedge clk); lu_in(3'd3, 3'd3); expect_v("reset_hold", V_RST);
    @(negedge clk); rst = 1'b0; idle(); expect_p("release_idle", V_RUN, 16'd0);

    // 1: load-use with MEM_LAT=1; redirect during LOAD_STALL is ignored.
    @(negedge clk); lu_in(3'd3, 3'd3); expect_v("lu_c0", V_LU);
    @(negedge clk); ex_redirect = 1'b1; expect_v("lu_c1_stall", V_LS);
    @(negedge clk); idle(); expect_p("lu_c2_run", V_RUN, 16'd2);

    // 2: no match when source registers are not read.
    @(negedge clk); lu_in(3'd3, 3'd3); id_uses_rs1 = 1'b0; id_rs2 = 3'd3;
                    expect_v("lu_unused_src", V_RUN);
    // rs2 match stalls.
    @(negedge clk); id_uses_rs2 = 1'b1; expect_v("lu_rs2_c0", V_LU);
    @(negedge clk); idle(); expect_v("lu_rs2_c1", V_LS);
    // Not a register write, and not valid: no stall.
    @(negedge clk); lu_in(3'd5, 3'd5); ex_rf_write_en = 1'b0; expect_v("lu_no_we", V_RUN);
    @(negedge clk); lu_in(3'd5, 3'd5); ex_valid = 1'b0; expect_v("lu_no_valid", V_RUN);
    @(negedge clk); lu_in(3'd5, 3'd4); expect_v("lu_rd_differs", V_RUN);
    // Register 0 is an ordinary index.
    @(negedge clk); lu_in(3'd0, 3'd0); expect_v("lu_r0_c0", V_LU);
    @(negedge clk); idle(); expect_v("lu_r0_c1", V_LS);

    // 3: redirect with FLUSH_DEPTH=2.
    @(negedge clk); idle(); ex_valid = 1'b1; ex_redirect = 1'b1; expect_v("redir_c0", V_RD);
    @(negedge clk); idle(); expect_v("redir_c1", V_FL);
    @(negedge clk); idle(); expect_v("redir_c2", V_RUN);

    // Redirect again while in FLUSH reloads the window.
    @(negedge clk); ex_valid = 1'b1; ex_redirect = 1'b1; expect_v("redir2_c0", V_RD);
    @(negedge clk); expect_v("redir2_in_flush", V_RDF);
    @(negedge clk); idle(); expect_v("redir2_c2", V_FL);
    @(negedge clk); idle(); expect_v("redir2_c3", V_RUN);

    // 4: redirect beats load-use; no LOAD_STALL.
    @(negedge clk); lu_in(3'd2, 3'd2); ex_redirect = 1'b1; expect_v("redir_lu_c0", V_RD);
    @(negedge clk); idle(); expect_v("redir_lu_c1", V_FL);
    @(negedge clk); idle(); expect_v("redir_lu_c2", V_RUN);

    // 5: stack conflict is a single-cycle bubble.
    @(negedge clk); idle(); ex_valid = 1'b1; ex_is_stack = 1'b1; id_is_stack = 1'b1;
                    expect_v("stk_c0", V_LU);
    @(negedge clk); idle(); expect_v("stk_c1", V_RUN);
    @(negedge clk); ex_is_stack = 1'b1; id_is_stack = 1'b1; expect_v("stk_not_valid", V_RUN);
    // Load-use beats stack conflict.
    @(negedge clk); lu_in(3'd6, 3'd6); ex_is_stack = 1'b1; id_is_stack = 1'b1;
                    expect_v("lu_stk_c0", V_LU);
    @(negedge clk); idle(); expect_v("lu_stk_c1", V_LS);
    @(negedge clk); idle(); expect_v("lu_stk_c2", V_RUN);

    // 6: reset asserted mid-stall, seen without a clock edge.
    @(negedge clk); lu_in(3'd3, 3'd3); expect_v("rst_lu_c0", V_LU);
    @(negedge clk); idle(); rst = 1'b1; expect_v("rst_async", V_RST);
    @(negedge clk); rst = 1'b0; expect_p("rst_release_run", V_RUN, 16'd0);
    @(negedge clk); expect_v("rst_release_run2", V_RUN);

    // Drain the scoreboard with a bounded wait.
    repeat (3) @(negedge clk);
    #4;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
